// File: rtl/mem_rd_pkg.sv
// rtl/mem_rd_pkg.sv - shared constants, state type and range helper for mem_burst_reader
package mem_rd_pkg;

  localparam int BURST     = 20;
  localparam int MEM_DEPTH = 1201;
  localparam int AW        = 16;
  localparam int IW        = $clog2(BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_DRAIN,
    S_FIN
  } state_t;

  // Widened by one bit so a start address near 2^AW cannot wrap into range.
  function automatic logic burst_fits(input logic [AW-1:0] addr);
    logic [AW:0] last_byte;
    last_byte = {1'b0, addr} + (AW+1)'(BURST - 1);
    return last_byte <= (AW+1)'(MEM_DEPTH - 1);
  endfunction

endpackage

// File: rtl/burst_ser_buf.sv
// rtl/burst_ser_buf.sv - parallel-load burst buffer serialised onto a valid/ready byte stream
module burst_ser_buf
  import mem_rd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BURST*8-1:0] load_data,
  input  logic               last_burst,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               out_eob,
  output logic               out_eoj,
  output logic               burst_end
);

  localparam logic [IW-1:0] LAST_IDX = IW'(BURST - 1);

  logic [7:0]    bytes_q [BURST];
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          xfer;

  assign xfer      = out_valid && out_ready;
  assign idx_nxt   = idx + IW'(1);
  assign burst_end = xfer && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < BURST; k++) begin
        bytes_q[k] <= load_data[k*8 +: 8];
      end
    end
  end

  // out_data is preloaded with the next byte so the stream port stays fully registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eob   <= 1'b0;
      out_eoj   <= 1'b0;
    end else if (load) begin
      idx       <= '0;
      out_valid <= 1'b1;
      out_data  <= load_data[7:0];
      out_eob   <= 1'b0;
      out_eoj   <= 1'b0;
    end else if (xfer) begin
      if (idx == LAST_IDX) begin
        out_valid <= 1'b0;
        out_eob   <= 1'b0;
        out_eoj   <= 1'b0;
      end else begin
        idx      <= idx_nxt;
        out_data <= bytes_q[idx_nxt];
        out_eob  <= (idx_nxt == LAST_IDX);
        out_eoj  <= (idx_nxt == LAST_IDX) && last_burst;
      end
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - read-side burst initiator: strided memory reads streamed out bytewise
module mem_burst_reader
  import mem_rd_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    n_bursts,
  input  logic [AW-1:0] stride,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_en,
  output logic          mem_r_w,
  output logic [AW-1:0] mem_abus,
  input  logic [7:0]    mem_dbus_out1,
  input  logic [7:0]    mem_dbus_out2,
  input  logic [7:0]    mem_dbus_out3,
  input  logic [7:0]    mem_dbus_out4,
  input  logic [7:0]    mem_dbus_out5,
  input  logic [7:0]    mem_dbus_out6,
  input  logic [7:0]    mem_dbus_out7,
  input  logic [7:0]    mem_dbus_out8,
  input  logic [7:0]    mem_dbus_out9,
  input  logic [7:0]    mem_dbus_out10,
  input  logic [7:0]    mem_dbus_out11,
  input  logic [7:0]    mem_dbus_out12,
  input  logic [7:0]    mem_dbus_out13,
  input  logic [7:0]    mem_dbus_out14,
  input  logic [7:0]    mem_dbus_out15,
  input  logic [7:0]    mem_dbus_out16,
  input  logic [7:0]    mem_dbus_out17,
  input  logic [7:0]    mem_dbus_out18,
  input  logic [7:0]    mem_dbus_out19,
  input  logic [7:0]    mem_dbus_out20,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_eob,
  output logic          out_eoj
);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] stride_q;
  logic [7:0]    remaining;
  logic          req_ok;
  logic          issue;
  logic          burst_end;
  logic [BURST*8-1:0] rd_bytes;

  assign rd_bytes = {mem_dbus_out20, mem_dbus_out19, mem_dbus_out18, mem_dbus_out17,
                     mem_dbus_out16, mem_dbus_out15, mem_dbus_out14, mem_dbus_out13,
                     mem_dbus_out12, mem_dbus_out11, mem_dbus_out10, mem_dbus_out9,
                     mem_dbus_out8,  mem_dbus_out7,  mem_dbus_out6,  mem_dbus_out5,
                     mem_dbus_out4,  mem_dbus_out3,  mem_dbus_out2,  mem_dbus_out1};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_addr  = cur_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_addr  = base_addr;
          next_state = (n_bursts == 8'd0) ? S_FIN : S_REQ;
        end
      end
      S_REQ:   next_state = req_ok ? S_CAP : S_FIN;
      S_CAP:   next_state = S_DRAIN;
      S_DRAIN: begin
        if (burst_end) begin
          next_addr  = cur_addr + stride_q;
          next_state = (remaining == 8'd1) ? S_FIN : S_REQ;
        end
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Range check is resolved on entry to REQ so mem_en can be a registered output.
  assign issue = (next_state == S_REQ) && burst_fits(next_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_r_w   <= 1'b1;
      mem_abus  <= '0;
      cur_addr  <= '0;
      stride_q  <= '0;
      remaining <= '0;
      req_ok    <= 1'b0;
    end else begin
      mem_r_w  <= 1'b1;
      busy     <= (next_state != S_IDLE);
      done     <= (next_state == S_FIN);
      err      <= (next_state == S_FIN) && (state == S_REQ);
      mem_en   <= issue;
      cur_addr <= next_addr;
      req_ok   <= burst_fits(next_addr);
      if (issue) mem_abus <= next_addr;
      if ((state == S_IDLE) && start) begin
        stride_q  <= stride;
        remaining <= n_bursts;
      end else if (burst_end) begin
        remaining <= remaining - 8'd1;
      end
    end
  end

  burst_ser_buf u_ser (
    .clk        (clk),
    .reset      (reset),
    .load       (state == S_CAP),
    .load_data  (rd_bytes),
    .last_burst (remaining == 8'd1),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_eob    (out_eob),
    .out_eoj    (out_eoj),
    .burst_end  (burst_end)
  );

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - self-checking bench for mem_burst_reader
module tb_mem_burst_reader;

  localparam int TB_BURST = 20;
  localparam int TB_DEPTH = 1201;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  n;
    logic [15:0] stride;
    int          mode;
    int          exp_err;
    int          exp_nbytes;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       eob;
    logic       eoj;
    int         c;
  } xfer_t;

  typedef struct {
    logic [15:0] a;
    int          c;
  } en_t;

  typedef struct {
    logic e;
    int   c;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  n_bursts = '0;
  logic [15:0] stride = '0;
  logic        busy, done, err, mem_en, mem_r_w;
  logic [15:0] mem_abus;
  logic [7:0]  out_data;
  logic        out_valid, out_eob, out_eoj;
  logic        out_ready = 1'b1;

  logic [7:0]  m  [0:TB_DEPTH-1];
  logic [7:0]  dq [1:20];

  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  int mode = 0;
  int pc = 0;
  bit [3:0] pat = 4'b1001;

  xfer_t got_x[$];
  en_t   got_a[$];
  done_t got_d[$];
  xfer_t exp_x[$];
  logic [15:0] exp_a[$];
  int    exp_err;

  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  vec_t tbl [11];

  mem_burst_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .n_bursts(n_bursts), .stride(stride), .busy(busy), .done(done), .err(err),
    .mem_en(mem_en), .mem_r_w(mem_r_w), .mem_abus(mem_abus),
    .mem_dbus_out1(dq[1]),   .mem_dbus_out2(dq[2]),   .mem_dbus_out3(dq[3]),
    .mem_dbus_out4(dq[4]),   .mem_dbus_out5(dq[5]),   .mem_dbus_out6(dq[6]),
    .mem_dbus_out7(dq[7]),   .mem_dbus_out8(dq[8]),   .mem_dbus_out9(dq[9]),
    .mem_dbus_out10(dq[10]), .mem_dbus_out11(dq[11]), .mem_dbus_out12(dq[12]),
    .mem_dbus_out13(dq[13]), .mem_dbus_out14(dq[14]), .mem_dbus_out15(dq[15]),
    .mem_dbus_out16(dq[16]), .mem_dbus_out17(dq[17]), .mem_dbus_out18(dq[18]),
    .mem_dbus_out19(dq[19]), .mem_dbus_out20(dq[20]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_eob(out_eob), .out_eoj(out_eoj)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scratch memory: registered read of 20 consecutive bytes.
  always @(posedge clk) begin
    if (mem_en && mem_r_w) begin
      for (int k = 1; k <= 20; k++) begin
        dq[k] <= (int'(mem_abus) + k - 1 < TB_DEPTH) ? m[int'(mem_abus) + k - 1] : 8'h00;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[pc % 4];
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      pc++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_x.push_back('{out_data, out_eob, out_eoj, cyc});
      if (mem_en) got_a.push_back('{mem_abus, cyc});
      if (done) got_d.push_back('{err, cyc});
      if (pv && !pr) begin
        chk("stall valid held", {31'd0, out_valid}, 32'd1);
        chk("stall data held", {24'd0, out_data}, {24'd0, pd});
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end else begin
      pv = 1'b0;
      pr = 1'b0;
    end
  end

  task automatic build_model(input logic [15:0] b, input logic [7:0] n, input logic [15:0] s);
    logic [15:0] a;
    exp_x.delete();
    exp_a.delete();
    exp_err = 0;
    a = b;
    for (int k = 0; k < int'(n); k++) begin
      if (int'(a) + TB_BURST - 1 > TB_DEPTH - 1) begin
        exp_err = 1;
        break;
      end
      exp_a.push_back(a);
      for (int j = 0; j < TB_BURST; j++) begin
        exp_x.push_back('{m[int'(a) + j], (j == TB_BURST - 1),
                          (j == TB_BURST - 1) && (k == int'(n) - 1), 0});
      end
      a = a + s;
    end
  endtask

  task automatic run_job(input string nm, input logic [15:0] b, input logic [7:0] n,
                         input logic [15:0] s, input int md, input int t_err, input int t_nb);
    int t0, exp_dc, nb, ec;
    bit seen, busy_low;
    build_model(b, n, s);
    got_x.delete();
    got_a.delete();
    got_d.delete();
    mode = md;
    @(posedge clk);
    #1;
    base_addr = b;
    n_bursts = n;
    stride = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    base_addr = 16'($urandom);
    n_bursts = 8'($urandom);
    stride = 16'($urandom);
    seen = 0;
    busy_low = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        start = (n != 8'd0) && (i == 3 || i == 30);
        if (!busy) busy_low = 1;
      end
    end
    start = 1'b0;
    chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
    chk({nm, " busy during job"}, {31'd0, busy_low}, 32'd0);
    if (seen) begin
      chk({nm, " busy at done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({nm, " busy after done"}, {31'd0, busy}, 32'd0);
      chk({nm, " done one cycle"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    nb = got_x.size();
    chk({nm, " byte count"}, nb, exp_x.size());
    if (t_nb >= 0) chk({nm, " table byte count"}, nb, t_nb);
    for (int j = 0; j < nb && j < exp_x.size(); j++) begin
      chk($sformatf("%s byte%0d data", nm, j), {24'd0, got_x[j].d}, {24'd0, exp_x[j].d});
      chk($sformatf("%s byte%0d eob/eoj", nm, j), {30'd0, got_x[j].eob, got_x[j].eoj},
          {30'd0, exp_x[j].eob, exp_x[j].eoj});
    end
    chk({nm, " burst count"}, got_a.size(), exp_a.size());
    for (int k = 0; k < got_a.size() && k < exp_a.size(); k++) begin
      chk($sformatf("%s abus%0d", nm, k), {16'd0, got_a[k].a}, {16'd0, exp_a[k]});
      ec = (k == 0) ? t0 : ((k * TB_BURST - 1 < nb) ? got_x[k * TB_BURST - 1].c + 1 : -1);
      chk($sformatf("%s en cycle%0d", nm, k), got_a[k].c, ec);
    end
    if (md == 0) begin
      for (int j = 0; j < nb; j++) begin
        if ((j % TB_BURST == 0 || j % TB_BURST == TB_BURST - 1) && (j / TB_BURST < got_a.size()))
          chk($sformatf("%s byte%0d cycle", nm, j), got_x[j].c,
              got_a[j / TB_BURST].c + 2 + j % TB_BURST);
      end
    end
    chk({nm, " done count"}, got_d.size(), 1);
    if (got_d.size() > 0) begin
      chk({nm, " err"}, {31'd0, got_d[0].e}, exp_err);
      if (t_err >= 0) chk({nm, " table err"}, {31'd0, got_d[0].e}, t_err);
      if (n == 8'd0) exp_dc = t0;
      else if (exp_err != 0) exp_dc = (nb == 0) ? t0 + 1 : got_x[nb - 1].c + 2;
      else exp_dc = (nb > 0) ? got_x[nb - 1].c + 1 : -1;
      chk({nm, " done cycle"}, got_d[0].c, exp_dc);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb, rs;
    logic [7:0]  rn;
    bit          rseen;
    tbl[0]  = '{16'd0,     8'd1, 16'd0,     0, 0, 20};
    tbl[1]  = '{16'd100,   8'd3, 16'd40,    0, 0, 60};
    tbl[2]  = '{16'd100,   8'd3, 16'd40,    1, 0, 60};
    tbl[3]  = '{16'd1180,  8'd2, 16'd1,     0, 0, 40};
    tbl[4]  = '{16'd1181,  8'd2, 16'd1,     0, 1, 20};
    tbl[5]  = '{16'd5,     8'd0, 16'd7,     0, 0, 0};
    tbl[6]  = '{16'd1182,  8'd1, 16'd0,     0, 1, 0};
    tbl[7]  = '{16'd1000,  8'd2, 16'd65036, 1, 0, 40};
    tbl[8]  = '{16'd65530, 8'd1, 16'd0,     0, 1, 0};
    tbl[9]  = '{16'd1100,  8'd3, 16'd50,    0, 1, 40};
    tbl[10] = '{16'd200,   8'd2, 16'd0,     1, 0, 40};

    for (int i = 0; i < TB_DEPTH; i++) m[i] = 8'(i & 8'hFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset mem_r_w", {31'd0, mem_r_w}, 32'd1);
    chk("reset mem_abus", {16'd0, mem_abus}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", {24'd0, out_data}, 32'd0);
    chk("reset out_eob", {31'd0, out_eob}, 32'd0);
    chk("reset out_eoj", {31'd0, out_eoj}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_job($sformatf("vec%0d", i), tbl[i].base, tbl[i].n, tbl[i].stride, tbl[i].mode,
              tbl[i].exp_err, tbl[i].exp_nbytes);

    // Reset in the middle of the second burst's drain.
    mode = 0;
    got_x.delete();
    got_a.delete();
    got_d.delete();
    @(posedge clk);
    #1;
    base_addr = 16'd100;
    n_bursts = 8'd3;
    stride = 16'd40;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rseen = 0;
    for (int i = 0; i < 200 && !rseen; i++) begin
      @(negedge clk);
      if (got_x.size() >= 25) rseen = 1;
    end
    chk("midreset reached burst2", {31'd0, rseen}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset mem_en", {31'd0, mem_en}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    got_a.delete();
    got_d.delete();
    repeat (40) @(negedge clk);
    chk("midreset no done", got_d.size(), 0);
    chk("midreset no reads", got_a.size(), 0);
    run_job("after reset", 16'd100, 8'd3, 16'd40, 0, 0, 60);

    for (int i = 0; i < TB_DEPTH; i++) m[i] = 8'($urandom);
    for (int r = 0; r < 12; r++) begin
      rb = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(65400, 65535))
                                       : 16'($urandom_range(0, 1250));
      rn = 8'($urandom_range(0, 4));
      rs = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400));
      run_job($sformatf("rnd%0d", r), rb, rn, rs, 2, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
